ps2_rx_fifo: RTL and testbench
==============================

// Module: ps2_rx_fifo
// PURPOSE
//  PS/2 device-to-host receiver with a parametrised scan-code FIFO, ps2_clk glitch filter,
//  inter-bit timeout and per-frame error reporting. Sits between the PS/2 pins and the
//  keyboard decoder/display logic; the consumer pops bytes via the ready/nextdata_n handshake.
// PARAMETERS
//  DEPTH_LOG2    3      FIFO depth = 2**DEPTH_LOG2 entries of 8 bits (DEPTH_LOG2 >= 1)
//  FILTER_LEN    4      clk cycles ps2_clk must hold a new level before it is accepted (>= 1)
//  TIMEOUT_CYC   5000   idle clk cycles mid-frame before the frame is aborted (>= 16)
// PORTS
//  clk          in   1               system clock
//  clrn         in   1               asynchronous reset, active low
//  ps2_clk      in   1               raw PS/2 clock pin (asynchronous)
//  ps2_data     in   1               raw PS/2 data pin (asynchronous)
//  nextdata_n   in   1               active-low pop request; honoured only while ready=1
//  err_clr      in   1               clears sticky error/overflow flags
//  data         out  8               FIFO head byte; valid while ready=1
//  ready        out  1               FIFO non-empty
//  level        out  DEPTH_LOG2+1    current FIFO occupancy, 0..2**DEPTH_LOG2
//  overflow     out  1               sticky: a good frame was dropped because FIFO full
//  parity_err   out  1               sticky: frame discarded on parity failure
//  frame_err    out  1               sticky: bad start/stop bit or timeout abort
// BEHAVIOUR
//  Reset (clrn=0, async): pointers, level, bit counter, timeout counter = 0; FSM=IDLE;
//   ready=0, overflow=0, parity_err=0, frame_err=0; filter and sync regs load 1 (idle bus).
//   FIFO storage not reset; data undefined until first push.
//  Input conditioning: ps2_clk, ps2_data each through 2-FF synchroniser. Filtered ps2_clk
//   changes only after FILTER_LEN consecutive identical synced samples. Sample strobe =
//   one-cycle pulse on filtered 1->0 transition; ps2_data (synced) captured on the strobe.
//  Frame: 11 bits, start(0), D0..D7 LSB first, odd parity, stop(1).
//  FSM: IDLE -strobe & data=0-> SHIFT; IDLE -strobe & data=1-> IDLE, frame_err<=1.
//   SHIFT: shift D0..D7 then parity (9 strobes) -> STOP.
//   STOP: on strobe evaluate; -> IDLE always.
//   Stop=1 & odd parity ok -> push byte. Stop=0 -> frame_err<=1, no push.
//   Stop=1 & parity bad -> parity_err<=1, no push.
//  Timeout: in SHIFT/STOP, counter increments each clk, cleared on strobe; reaching
//   TIMEOUT_CYC -> FSM=IDLE, frame_err<=1, partial byte dropped. Counter held 0 in IDLE.
//  Push: registered on the cycle after the stop strobe; byte visible on data and ready=1
//   one clk after push if FIFO was empty (data is combinational read of fifo[r_ptr]).
//  Pop: nextdata_n=0 & ready=1 at posedge -> r_ptr++, level--. nextdata_n ignored when empty.
//  Full: push while level=DEPTH and no pop same cycle -> byte dropped, contents unchanged,
//   overflow<=1. Push and pop same cycle when full -> both succeed, level unchanged.
//   Simultaneous push/pop at any level -> level unchanged, pointers both advance.
//  Pointers are DEPTH_LOG2 bits and wrap modulo depth; full/empty from level, not pointers.
//  ready = (level != 0). level is DEPTH_LOG2+1 bits so DEPTH is representable.
//  err_clr=1: clears overflow, parity_err, frame_err; a set event in the same cycle wins.
//  No error ever alters FIFO contents or pointers.
// TESTING
//  Send 0x1C (parity 0,stop 1) -> ready=1, data=0x1C, level=1; pop -> ready=0, level=0.
//  Send 0xF0,0x1C,0xE0 no pops -> level=3, pops return F0,1C,E0 in order.
//  Send DEPTH+1 frames (DEPTH=8) no pops -> level=8, overflow=1, 9th byte absent; err_clr -> 0.
//  Frame 0x55 with parity bit flipped -> parity_err=1, level unchanged; stop=0 -> frame_err=1.
//  Stop ps2_clk after 5 bits > TIMEOUT_CYC -> frame_err=1; next clean 0x29 received correctly.
//  1-cycle ps2_clk low glitches mid-idle -> no strobe, FSM stays IDLE; clrn low mid-frame -> all 0.

Source files
------------

// File: rtl/ps2_rx_fifo_if.sv
// Consumer-side bus of the PS/2 receiver: pop handshake, head byte, occupancy and
// sticky error flags. The receiver takes the master modport, the consumer the slave.
interface ps2_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 3
);
  logic                  nextdata_n;
  logic                  err_clr;
  logic [7:0]            data;
  logic                  ready;
  logic [DEPTH_LOG2:0]   level;
  logic                  overflow;
  logic                  parity_err;
  logic                  frame_err;

  modport master (
    input  nextdata_n, err_clr,
    output data, ready, level, overflow, parity_err, frame_err
  );

  modport slave (
    output nextdata_n, err_clr,
    input  data, ready, level, overflow, parity_err, frame_err
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronised and glitch-filtered ps2_clk, 11-bit frame
// FSM with inter-bit timeout, sticky error flags and a scan-code FIFO for the consumer.
module ps2_rx_fifo #(
  parameter int DEPTH_LOG2  = 3,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic            ps2_clk,
  input  logic            ps2_data,
  ps2_rx_fifo_if.master   bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int FCW   = $clog2(FILTER_LEN + 1);
  localparam int TCW   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [FCW-1:0]      FILT_LAST = FCW'(FILTER_LEN - 1);
  localparam logic [TCW-1:0]      TO_LAST   = TCW'(TIMEOUT_CYC - 1);
  localparam logic [DEPTH_LOG2:0] LVL_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------- conditioning
  logic [1:0]     r_clk_sync;
  logic [1:0]     r_data_sync;
  logic           r_clk_filt;
  logic [FCW-1:0] r_filt_cnt;
  logic           w_filt_done;
  logic           w_strobe;
  logic           w_bit;

  // Filtered level flips only once the synced pin has disagreed for FILTER_LEN samples.
  assign w_filt_done = (r_clk_sync[1] != r_clk_filt) && (r_filt_cnt == FILT_LAST);
  assign w_strobe    = w_filt_done && r_clk_filt;
  assign w_bit       = r_data_sync[1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_clk_filt  <= 1'b1;
      r_filt_cnt  <= '0;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], ps2_clk};
      r_data_sync <= {r_data_sync[0], ps2_data};
      if (r_clk_sync[1] == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (w_filt_done) begin
        r_clk_filt <= r_clk_sync[1];
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- frame FSM
  state_t         r_state;
  logic [8:0]     r_shift;
  logic [3:0]     r_bit_cnt;
  logic [TCW-1:0] r_to_cnt;
  logic           r_push;
  logic [7:0]     r_push_byte;
  logic           r_parity_err;
  logic           r_frame_err;

  // Error sets are written after the clear so a same-cycle event wins over err_clr.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_to_cnt     <= '0;
      r_push       <= 1'b0;
      r_push_byte  <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_push <= 1'b0;
      if (bus.err_clr) begin
        r_parity_err <= 1'b0;
        r_frame_err  <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          r_to_cnt <= '0;
          if (w_strobe) begin
            if (!w_bit) begin
              r_state   <= S_SHIFT;
              r_bit_cnt <= '0;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          if (w_strobe) begin
            r_to_cnt  <= '0;
            r_shift   <= {w_bit, r_shift[8:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 4'd8) r_state <= S_STOP;
          end else if (r_to_cnt == TO_LAST) begin
            r_to_cnt    <= '0;
            r_state     <= S_IDLE;
            r_frame_err <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_strobe) begin
            r_to_cnt <= '0;
            r_state  <= S_IDLE;
            if (!w_bit) begin
              r_frame_err <= 1'b1;
            end else if (^r_shift) begin
              r_push      <= 1'b1;
              r_push_byte <= r_shift[7:0];
            end else begin
              r_parity_err <= 1'b1;
            end
          end else if (r_to_cnt == TO_LAST) begin
            r_to_cnt    <= '0;
            r_state     <= S_IDLE;
            r_frame_err <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- FIFO
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_overflow;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_wr;

  assign w_pop  = !bus.nextdata_n && (r_level != '0);
  assign w_full = (r_level == LVL_FULL);
  assign w_wr   = r_push && (!w_full || w_pop);

  // NOTE: storage has no reset; empty/full come from r_level, so stale entries are never read.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= r_push_byte;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (bus.err_clr) r_overflow <= 1'b0;
      if (r_push && w_full && !w_pop) r_overflow <= 1'b1;
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign bus.data       = r_mem[r_rptr];
  assign bus.ready      = (r_level != '0);
  assign bus.level      = r_level;
  assign bus.overflow   = r_overflow;
  assign bus.parity_err = r_parity_err;
  assign bus.frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: clean frames, FIFO order and overflow, parity/stop
// errors, inter-bit timeout, ps2_clk glitches and reset mid-frame.
module tb_ps2_rx_fifo;

  localparam int DEPTH_LOG2 = 3;
  localparam int FILTER_LEN = 4;
  localparam int TO_CYC     = 5000;
  localparam int HALF       = 10;

  logic clk = 1'b0;
  logic clrn;
  logic ps2_clk;
  logic ps2_data;

  int total = 0;
  int bad   = 0;

  ps2_rx_fifo_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

  ps2_rx_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk     (clk),
    .clrn    (clrn),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives bits LSB first; data set while ps2_clk is high, host samples on the falling edge.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      cyc(HALF);
      ps2_clk = 1'b0;
      cyc(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic stop);
    logic p;
    p = (~^b) ^ flip_par;
    send_bits({stop, p, b, 1'b0}, 11);
    ps2_data = 1'b1;
    cyc(2 * HALF);
  endtask

  task automatic pop();
    bus.nextdata_n = 1'b0;
    cyc(1);
    bus.nextdata_n = 1'b1;
    cyc(1);
  endtask

  task automatic pulse_clr();
    bus.err_clr = 1'b1;
    cyc(1);
    bus.err_clr = 1'b0;
    cyc(1);
  endtask

  initial begin
    logic [7:0] seq3 [3];
    seq3[0] = 8'hF0;
    seq3[1] = 8'h1C;
    seq3[2] = 8'hE0;

    clrn           = 1'b0;
    ps2_clk        = 1'b1;
    ps2_data       = 1'b1;
    bus.nextdata_n = 1'b1;
    bus.err_clr    = 1'b0;
    cyc(3);

    // Reset state
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_flags", {29'd0, bus.overflow, bus.parity_err, bus.frame_err}, 32'd0);
    clrn = 1'b1;
    cyc(5);

    // Single clean frame, then pop
    send_frame(8'h1C, 1'b0, 1'b1);
    check("one_ready", 32'(bus.ready), 32'd1);
    check("one_data",  32'(bus.data),  32'h1C);
    check("one_level", 32'(bus.level), 32'd1);
    pop();
    check("one_pop_ready", 32'(bus.ready), 32'd0);
    check("one_pop_level", 32'(bus.level), 32'd0);

    // Three frames, FIFO order
    for (int i = 0; i < 3; i++) send_frame(seq3[i], 1'b0, 1'b1);
    check("three_level", 32'(bus.level), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("three_data%0d", i), 32'(bus.data), 32'(seq3[i]));
      pop();
    end
    check("three_empty", 32'(bus.level), 32'd0);

    // Pop request while empty is ignored
    pop();
    check("empty_pop_level", 32'(bus.level), 32'd0);

    // DEPTH+1 frames without pops: overflow, ninth byte dropped
    for (int i = 0; i < 9; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b1);
    check("full_level",    32'(bus.level),    32'd8);
    check("full_overflow", 32'(bus.overflow), 32'd1);
    check("full_other",    {30'd0, bus.parity_err, bus.frame_err}, 32'd0);
    pulse_clr();
    check("ovf_cleared", 32'(bus.overflow), 32'd0);
    check("ovf_level",   32'(bus.level),    32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("full_data%0d", i), 32'(bus.data), 32'h10 + 32'(i));
      pop();
    end
    check("full_drained", 32'(bus.level), 32'd0);

    // Parity error
    send_frame(8'h55, 1'b1, 1'b1);
    check("par_err",   32'(bus.parity_err), 32'd1);
    check("par_level", 32'(bus.level),      32'd0);
    check("par_frame", 32'(bus.frame_err),  32'd0);
    pulse_clr();
    check("par_cleared", 32'(bus.parity_err), 32'd0);

    // Bad stop bit
    send_frame(8'h55, 1'b0, 1'b0);
    check("stop_frame_err", 32'(bus.frame_err),  32'd1);
    check("stop_parity",    32'(bus.parity_err), 32'd0);
    check("stop_level",     32'(bus.level),      32'd0);
    pulse_clr();

    // Timeout after start + 4 data bits, then a clean frame
    send_bits({1'b1, 1'b0, 8'h29, 1'b0}, 5);
    ps2_data = 1'b1;
    cyc(TO_CYC / 2);
    check("to_pending", 32'(bus.frame_err), 32'd0);
    cyc(TO_CYC / 2 + 100);
    check("to_frame_err", 32'(bus.frame_err), 32'd1);
    check("to_level",     32'(bus.level),     32'd0);
    pulse_clr();
    send_frame(8'h29, 1'b0, 1'b1);
    check("to_next_data",  32'(bus.data),      32'h29);
    check("to_next_level", 32'(bus.level),     32'd1);
    check("to_next_ferr",  32'(bus.frame_err), 32'd0);
    pop();

    // Short ps2_clk glitches (1 and FILTER_LEN-1 cycles) while idle
    for (int w = 1; w < FILTER_LEN; w += FILTER_LEN - 2) begin
      for (int k = 0; k < 3; k++) begin
        ps2_clk = 1'b0;
        cyc(w);
        ps2_clk = 1'b1;
        cyc(10);
      end
    end
    check("glitch_ferr",  32'(bus.frame_err), 32'd0);
    check("glitch_level", 32'(bus.level),     32'd0);
    send_frame(8'h3A, 1'b0, 1'b1);
    check("glitch_after", 32'(bus.data), 32'h3A);
    pop();

    // Reset mid-frame with a byte stored and a flag set
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h44, 1'b0, 1'b0);
    check("pre_rst_level", 32'(bus.level),     32'd1);
    check("pre_rst_ferr",  32'(bus.frame_err), 32'd1);
    send_bits({1'b1, 1'b1, 8'hA5, 1'b0}, 6);
    clrn     = 1'b0;
    ps2_data = 1'b1;
    ps2_clk  = 1'b1;
    cyc(2);
    check("mid_rst_level", 32'(bus.level), 32'd0);
    check("mid_rst_ready", 32'(bus.ready), 32'd0);
    check("mid_rst_flags", {29'd0, bus.overflow, bus.parity_err, bus.frame_err}, 32'd0);
    clrn = 1'b1;
    cyc(5);
    send_frame(8'h77, 1'b0, 1'b1);
    check("post_rst_data",  32'(bus.data),  32'h77);
    check("post_rst_level", 32'(bus.level), 32'd1);
    check("post_rst_flags", {29'd0, bus.overflow, bus.parity_err, bus.frame_err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
